// File: rtl/uart_rx_8x.sv
// uart_rx_8x: UART receiver, 8 clk per prescale unit per bit, AXI-Stream style output with one-word holding register
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rxd             asynchronous serial line, idle high
//   prescale        bit period = prescale*8 clk cycles, captured at start detection
//   m_axis_tdata    received word
//   m_axis_tvalid   word held in output register
//   m_axis_tready   consumer accepts word
//   busy            frame reception in progress
//   frame_error     one-cycle pulse, stop bit sampled low
//   overrun_error   one-cycle pulse, new word completed while previous word was unaccepted
module uart_rx_8x #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic [15:0]           prescale,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  frame_error,
    output logic                  overrun_error
);
    localparam int BW = $clog2(DATA_WIDTH + 3) < 1 ? 1 : $clog2(DATA_WIDTH + 3);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

    logic                  rxd_m, rxd_s, rxd_p, armed;
    logic [1:0]            fill;
    logic [1:0]            state;
    logic [18:0]           cnt;
    logic [15:0]           p;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  fall, tick;
    logic [18:0]           full;

    // Edges only count once rxd_s has carried a real high since reset, so a
    // line held low through reset cannot masquerade as a start bit.
    assign fall = armed & rxd_p & ~rxd_s;
    assign tick = cnt == 19'd0;
    assign full = {p, 3'b000} - 19'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m         <= 1'b1;
            rxd_s         <= 1'b1;
            rxd_p         <= 1'b1;
            fill          <= 2'b00;
            armed         <= 1'b0;
            state         <= IDLE;
            cnt           <= '0;
            p             <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            frame_error   <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            rxd_m         <= rxd;
            rxd_s         <= rxd_m;
            rxd_p         <= rxd_s;
            // fill[1] marks rxd_s as holding a genuine line sample
            fill          <= {fill[0], 1'b1};
            armed         <= armed | (fill[1] & rxd_s);
            frame_error   <= 1'b0;
            overrun_error <= 1'b0;
            if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
            if (!tick) cnt <= cnt - 19'd1;
            case (state)
                IDLE: if (fall && prescale != 16'd0) begin
                    p     <= prescale;
                    cnt   <= {1'b0, prescale, 2'b00} - 19'd1;
                    busy  <= 1'b1;
                    state <= START;
                end
                START: if (tick) begin
                    if (!rxd_s) begin
                        cnt     <= full;
                        bit_cnt <= BW'(DATA_WIDTH);
                        state   <= DATA;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                DATA: if (tick) begin
                    shreg   <= {rxd_s, shreg[DATA_WIDTH-1:1]};
                    cnt     <= full;
                    bit_cnt <= bit_cnt - BW'(1);
                    if (bit_cnt == BW'(1)) state <= STOP;
                end
                default: if (tick) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (rxd_s) begin
                        // a write in the same cycle as an accept keeps tvalid high
                        m_axis_tdata  <= shreg;
                        m_axis_tvalid <= 1'b1;
                        overrun_error <= m_axis_tvalid & ~m_axis_tready;
                    end else begin
                        frame_error <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_8x.sv
// tb_uart_rx_8x: directed and randomized checks of uart_rx_8x at 8- and 16-bit widths against a frame-level model
module tb_uart_rx_8x;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd8 = 1'b1, rxd16 = 1'b1;
    logic [15:0] prescale = 16'd1;
    logic        rdy8 = 1'b1, rdy16 = 1'b1;
    logic [7:0]  td8;
    logic [15:0] td16;
    logic        tv8, tv16, busy8, busy16, fe8, fe16, oe8, oe16;
    logic        tog16 = 1'b0;

    int n_assert = 0, n_fail = 0;
    int fe8_n = 0, oe8_n = 0, busy8_n = 0, fe16_n = 0, oe16_n = 0, busy16_n = 0;
    logic [7:0]  got8[$], exp8[$];
    logic [15:0] got16[$], exp16[$];
    int          exp_fe8 = 0, exp_oe8 = 0;
    logic        held8 = 1'b0;
    logic [7:0]  hw8 = 8'h00;

    always #5 clk = ~clk;

    uart_rx_8x #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .rxd(rxd8), .prescale(prescale),
        .m_axis_tdata(td8), .m_axis_tvalid(tv8), .m_axis_tready(rdy8),
        .busy(busy8), .frame_error(fe8), .overrun_error(oe8)
    );

    uart_rx_8x #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .rxd(rxd16), .prescale(prescale),
        .m_axis_tdata(td16), .m_axis_tvalid(tv16), .m_axis_tready(rdy16),
        .busy(busy16), .frame_error(fe16), .overrun_error(oe16)
    );

    // Observe transfers and pulses mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (tv8 && rdy8) got8.push_back(td8);
            if (tv16 && rdy16) got16.push_back(td16);
            if (fe8) fe8_n++;
            if (oe8) oe8_n++;
            if (busy8) busy8_n++;
            if (fe16) fe16_n++;
            if (oe16) oe16_n++;
            if (busy16) busy16_n++;
        end
    end

    always @(posedge clk) begin
        #2;
        if (tog16) rdy16 = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic line(input bit wide, input logic v, input int n);
        if (wide) rxd16 = v;
        else rxd8 = v;
        tick(n);
    endtask

    task automatic send(input bit wide, input logic [15:0] d, input int p, input logic stop);
        prescale = 16'(p);
        line(wide, 1'b0, 8 * p);
        for (int i = 0; i < (wide ? 16 : 8); i++) line(wide, d[i], 8 * p);
        line(wide, stop, 8 * p);
        line(wide, 1'b1, 0);
    endtask

    // Frame-level model of the 8-bit receiver's output slot.
    task automatic frame8(input logic [7:0] d, input int p, input logic stop);
        send(1'b0, {8'h00, d}, p, stop);
        if (!stop) exp_fe8++;
        else if (rdy8) exp8.push_back(d);
        else begin
            if (held8) exp_oe8++;
            held8 = 1'b1;
            hw8 = d;
        end
    endtask

    task automatic release8();
        rdy8 = 1'b1;
        if (held8) exp8.push_back(hw8);
        held8 = 1'b0;
    endtask

    task automatic cmp8(input string tag);
        chk({tag, "_n"}, 64'(got8.size()), 64'(exp8.size()));
        for (int i = 0; i < exp8.size() && i < got8.size(); i++) chk(tag, 64'(got8[i]), 64'(exp8[i]));
        chk({tag, "_fe"}, 64'(fe8_n), 64'(exp_fe8));
        chk({tag, "_oe"}, 64'(oe8_n), 64'(exp_oe8));
    endtask

    initial begin
        logic [7:0]  d8;
        logic [15:0] d16;
        int          p;
        tick(2);
        chk("rst_tvalid", 64'(tv8), 64'd0);
        chk("rst_tdata", 64'(td8), 64'd0);
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_err", 64'({fe8, oe8, fe16, oe16}), 64'd0);
        chk("rst_tdata16", 64'(td16), 64'd0);
        rst = 1'b0;
        tick(6);

        busy8_n = 0;
        frame8(8'hA5, 1, 1'b1);
        tick(4);
        chk("t1_busy", 64'(busy8_n), 64'd76);
        cmp8("t1");

        for (int k = 0; k < 4; k++) begin
            p = int'($urandom_range(1, 3));
            d8 = 8'($urandom);
            busy8_n = 0;
            frame8(d8, p, 1'b1);
            tick(4);
            chk("rnd_busy", 64'(busy8_n), 64'(4 * p + 8 * p * 8 + 8 * p));
            cmp8("rnd");
        end

        rdy8 = 1'b0;
        frame8(8'h3C, 4, 1'b1);
        tick(4);
        chk("t2_tvalid1", 64'(tv8), 64'd1);
        chk("t2_hold1", 64'(td8), 64'(hw8));
        frame8(8'hC3, 4, 1'b1);
        tick(4);
        chk("t2_tvalid2", 64'(tv8), 64'd1);
        chk("t2_hold2", 64'(td8), 64'(hw8));
        cmp8("t2");
        release8();
        tick(3);
        chk("t2_drain", 64'(tv8), 64'd0);
        cmp8("t2_after");

        frame8(8'h5A, 2, 1'b0);
        tick(4);
        chk("t3_tvalid", 64'(tv8), 64'd0);
        cmp8("t3_fe");
        frame8(8'h11, 2, 1'b1);
        tick(4);
        cmp8("t3_ok");

        prescale = 16'd2;
        busy8_n = 0;
        line(1'b0, 1'b0, 4);
        line(1'b0, 1'b1, 20);
        chk("t4_busy", 64'(busy8_n), 64'd8);
        chk("t4_tvalid", 64'(tv8), 64'd0);
        cmp8("t4");

        rdy8 = 1'b0;
        frame8(8'h42, 2, 1'b1);
        tick(4);
        chk("t5_held", 64'(tv8), 64'd1);
        line(1'b0, 1'b0, 16);
        line(1'b0, 1'b1, 32);
        line(1'b0, 1'b0, 3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        held8 = 1'b0;
        chk("t5_tvalid", 64'(tv8), 64'd0);
        chk("t5_tdata", 64'(td8), 64'd0);
        chk("t5_busy", 64'(busy8), 64'd0);
        busy8_n = 0;
        tick(40);
        chk("t5_lowidle", 64'(busy8_n), 64'd0);
        line(1'b0, 1'b1, 16);
        rdy8 = 1'b1;
        frame8(8'h81, 2, 1'b1);
        tick(4);
        cmp8("t5");

        tog16 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            d16 = k == 0 ? 16'hBEEF : k == 1 ? 16'h0001 : k == 2 ? 16'h8000 : 16'($urandom);
            busy16_n = 0;
            send(1'b1, d16, 3, 1'b1);
            exp16.push_back(d16);
            tick(6);
            chk("t6_busy", 64'(busy16_n), 64'(4 * 3 + 8 * 3 * 16 + 8 * 3));
        end
        tog16 = 1'b0;
        tick(1);
        rdy16 = 1'b1;
        tick(4);
        chk("t6_n", 64'(got16.size()), 64'(exp16.size()));
        for (int i = 0; i < exp16.size() && i < got16.size(); i++) chk("t6_word", 64'(got16[i]), 64'(exp16[i]));
        chk("t6_err", 64'(fe16_n + oe16_n), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
